// File: rtl/cordic_out_scaler_pkg.sv
// Shared constants for the CORDIC output scaler.
//   K_Q20     : CORDIC gain compensation K = 0.6072529350 as unsigned Q0.20
//   FRAC_BITS : fractional bits of K_Q20, also the product right-shift
//   RND       : half-LSB added before the shift (round half-up)
//   rec_width : width of one buffered result record {a, b, p, q, angle}
package cordic_out_scaler_pkg;

    localparam int unsigned FRAC_BITS = 20;
    localparam logic [19:0] K_Q20     = 20'h9B74F;  // 636751
    localparam int unsigned RND       = 1 << (FRAC_BITS - 1);
    localparam int unsigned NUM_CH    = 4;          // a, b, p, q

    function automatic int unsigned rec_width(input int unsigned dw, input int unsigned aw);
        return NUM_CH * dw + aw;
    endfunction

endpackage

// File: rtl/cordic_out_scaler_sync_fifo.sv
// Synchronous FIFO with a registered head.
//   clk, rst   : clock, synchronous active-high reset
//   push, wdata: write one entry (never issued while full)
//   pop        : consume the head; ignored when empty
//   rvalid     : head holds an entry
//   rdata      : head entry, zero when empty
//   count      : number of stored entries
module cordic_out_scaler_sync_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [Width-1:0]           wdata,
    input  logic                       pop,
    output logic                       rvalid,
    output logic [Width-1:0]           rdata,
    output logic [$clog2(Depth+1)-1:0] count
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned CntW  = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             pop_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        pop_ok   = pop && (cnt_q != '0);
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;  // power-of-2 depth: wraps naturally
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop_ok && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rvalid = (cnt_q != '0);
    assign rdata  = rvalid ? mem_q[rd_ptr_q] : '0;
    assign count  = cnt_q;

    // Upstream credits make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (cnt_q == CntW'(Depth))));

endmodule

// File: rtl/cordic_out_scaler.sv
// Output stage of the doubly pipelined CORDIC core.
// Follows each legal issue through the core latency with a token shift register, captures
// af/bf/pf/qf and the angle when the token emerges, multiplies by K (two register stages)
// and buffers the result in a FIFO. Issue is throttled by credits: every issued operand
// owns a FIFO slot until its result is popped, so nothing is ever lost.
//   clk, rst          : clock, synchronous active-high reset
//   issue/issue_ready : operands presented to the core / a credit is free
//   af,bf,pf,qf       : raw gain-inflated core outputs, signed Q11.20
//   in_angle          : core output angle, passed through
//   out_valid/ready   : FIFO head handshake
//   out_a..out_q      : scaled results, out_angle: matching angle (all 0 when empty)
//   err_overrun       : sticky, set by an issue while issue_ready is low
//   drop_cnt          : number of such illegal issues, saturating at 255
module cordic_out_scaler
    import cordic_out_scaler_pkg::*;
#(
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 32,
    parameter int unsigned PIPE_LAT   = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    output logic          issue_ready,
    input  logic [DW-1:0] af,
    input  logic [DW-1:0] bf,
    input  logic [DW-1:0] pf,
    input  logic [DW-1:0] qf,
    input  logic [AW-1:0] in_angle,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [DW-1:0] out_p,
    output logic [DW-1:0] out_q,
    output logic [AW-1:0] out_angle,
    output logic          err_overrun,
    output logic [7:0]    drop_cnt
);

    localparam int unsigned PW = DW + 21;  // signed DW x unsigned 20-bit product
    localparam int unsigned RW = rec_width(DW, AW);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic                issue_legal, issue_bad, pop, cap;
    logic [PIPE_LAT-1:0] tok_q, tok_d;
    logic                init_done_q;
    logic [CW-1:0]       used_q, used_d;
    logic                err_q, err_d;
    logic [7:0]          drop_q, drop_d;
    logic                s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic [AW-1:0]       s1_ang_q, s1_ang_d, s2_ang_q, s2_ang_d;
    logic [DW-1:0]       raw    [NUM_CH];
    logic [DW-1:0]       scaled [NUM_CH];
    logic [RW-1:0]       push_data, head_data;
    logic [CW-1:0]       fifo_cnt;

    // issue_ready is held low for one cycle after reset so that it rises the cycle after
    // rst deasserts; it depends only on registered state.
    assign issue_ready = init_done_q && (used_q < CW'(FIFO_DEPTH));
    assign issue_legal = issue && issue_ready;
    assign issue_bad   = issue && !issue_ready;
    assign pop         = out_valid && out_ready;
    assign cap         = tok_q[PIPE_LAT-1];

    assign raw[0] = af;
    assign raw[1] = bf;
    assign raw[2] = pf;
    assign raw[3] = qf;

    always_comb begin
        tok_d    = tok_q << 1;
        tok_d[0] = issue_legal;

        used_d = used_q;
        if (issue_legal && !pop) begin
            used_d = used_q + 1'b1;
        end else if (pop && !issue_legal) begin
            used_d = used_q - 1'b1;
        end

        err_d  = err_q | issue_bad;
        drop_d = (issue_bad && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

        s1_vld_d = cap;
        s1_ang_d = in_angle;
        s2_vld_d = s1_vld_q;
        s2_ang_d = s1_ang_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tok_q       <= '0;
            init_done_q <= 1'b0;
            used_q      <= '0;
            err_q       <= 1'b0;
            drop_q      <= '0;
            s1_vld_q    <= 1'b0;
            s1_ang_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_ang_q    <= '0;
        end else begin
            tok_q       <= tok_d;
            init_done_q <= 1'b1;
            used_q      <= used_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
            s1_vld_q    <= s1_vld_d;
            s1_ang_q    <= s1_ang_d;
            s2_vld_q    <= s2_vld_d;
            s2_ang_q    <= s2_ang_d;
        end
    end

    // Per channel: stage 1 registers x * K_Q20, stage 2 registers the rounded product.
    // K < 1 so the result always fits back into DW bits.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic signed [PW-1:0] prod_q, prod_d, rnd_sum;
        logic        [DW-1:0] y_q, y_d;

        always_comb begin
            prod_d  = PW'($signed(raw[i])) * $signed(PW'(K_Q20));
            rnd_sum = prod_q + $signed(PW'(RND));
            y_d     = DW'(rnd_sum >>> FRAC_BITS);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                prod_q <= '0;
                y_q    <= '0;
            end else begin
                prod_q <= prod_d;
                y_q    <= y_d;
            end
        end

        assign scaled[i] = y_q;
    end

    assign push_data = {scaled[0], scaled[1], scaled[2], scaled[3], s2_ang_q};

    cordic_out_scaler_sync_fifo #(
        .Width (RW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (s2_vld_q),
        .wdata  (push_data),
        .pop    (pop),
        .rvalid (out_valid),
        .rdata  (head_data),
        .count  (fifo_cnt)
    );

    assign {out_a, out_b, out_p, out_q, out_angle} = head_data;
    assign err_overrun = err_q;
    assign drop_cnt    = drop_q;

    // Every stored entry still holds its credit.
    a_credit_cover: assert property (@(posedge clk) disable iff (rst) fifo_cnt <= used_q);

endmodule
